// File: rtl/nand_sched_pkg.sv
// Shared types, defaults and round-robin pick helper for nand_rr_scheduler.
// Optional grant statistics are enabled with NAND_SCHED_STATS_EN.
package nand_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int MAX_REQ     = 64;

  // First set bit at or above ptr, wrapping at n back to 0.
  function automatic int rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int                 ptr,
    input int                 n
  );
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[5:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/nand_eval_unit.sv
// Operand capture plus registered bitwise NAND.
// Result register only updates the cycle after a load.
module nand_eval_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic             ld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      y_q  <= '0;
      ld_q <= 1'b0;
    end else begin
      ld_q <= load;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
      if (ld_q) y_q <= ~(a_q & b_q);
    end
  end

  assign y = y_q;

endmodule

// File: rtl/nand_rr_scheduler.sv
// Round-robin scheduler sharing one NAND evaluation unit.
// Define NAND_SCHED_STATS_EN to add the saturating grant_cnt_o counter.
module nand_rr_scheduler
  import nand_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
`ifdef NAND_SCHED_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic                       busy_o
`ifdef NAND_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]           grant_cnt_o
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic [ID_W-1:0]   id_q;
  logic              valid_q;
  logic              busy_q;

  logic [MAX_REQ-1:0] req_ext;
  int                 pick_idx;
  logic [ID_W-1:0]    pick_id;
  logic               grant;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;

  always_comb begin
    req_ext  = MAX_REQ'(req_i);
    pick_idx = rr_pick(req_ext, int'(ptr_q), NUM_REQ);
    pick_id  = ID_W'(pick_idx);
    grant    = rst_n && ena && (state_q == IDLE) && (|req_i);
    gnt_o    = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == k) begin
        gnt_o[k] = grant;
        a_sel    = op_a_i[k*WIDTH +: WIDTH];
        b_sel    = op_b_i[k*WIDTH +: WIDTH];
      end
    end
    // Explicit wrap so non-power-of-two NUM_REQ works.
    ptr_d = (pick_idx == NUM_REQ - 1) ? '0 : pick_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= EVAL;
            busy_q  <= 1'b1;
            id_q    <= pick_id;
            ptr_q   <= ptr_d;
          end
        end
        EVAL: begin
          state_q <= RESP;
          valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  nand_eval_unit #(
    .WIDTH (WIDTH)
  ) u_eval (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant),
    .a     (a_sel),
    .b     (b_sel),
    .y     (rsp_data_o)
  );

  assign rsp_valid_o = valid_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = busy_q;

`ifdef NAND_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (grant && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_nand_rr_scheduler.sv
// Randomised and directed bench for nand_rr_scheduler.
// Compares every cycle against a transaction-level reference model.
module tb_nand_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         ready;
  logic [N-1:0]   req;
  logic [N*W-1:0] opa;
  logic [N*W-1:0] opb;
  logic [N-1:0]   gnt;
  logic           valid;
  logic           busy;
  logic [W-1:0]   data;
  logic [IW-1:0]  id;
`ifdef NAND_SCHED_STATS_EN
  logic [3:0]     cnt;
`endif

  always #5 clk = ~clk;

  nand_rr_scheduler #(
    .NUM_REQ (N),
    .WIDTH   (W)
`ifdef NAND_SCHED_STATS_EN
    ,
    .CNT_W   (4)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req_i       (req),
    .op_a_i      (opa),
    .op_b_i      (opb),
    .gnt_o       (gnt),
    .rsp_valid_o (valid),
    .rsp_ready_i (ready),
    .rsp_data_o  (data),
    .rsp_id_o    (id),
    .busy_o      (busy)
`ifdef NAND_SCHED_STATS_EN
    ,
    .grant_cnt_o (cnt)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: pointer, job phase (0 none, 1 computing, 2 waiting)
  int         m_ptr;
  int         m_phase;
  int         m_id;
  int         m_cnt;
  logic [W-1:0] m_data;
  bit         m_known = 0;
  int         last_k;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (m_ptr + i) % N;
      if (r[j[IW-1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic step(input logic rs, input logic en, input logic rdy,
                      input logic [N-1:0] rq,
                      input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b);
    int k;
    logic [N-1:0] eg;
    @(negedge clk);
    rst_n = rs;
    ena   = en;
    ready = rdy;
    req   = rq;
    opa   = a;
    opb   = b;
    #1;
    k  = (m_known && rs && en && m_phase == 0) ? rr(rq) : -1;
    eg = '0;
    if (k >= 0) eg[k[IW-1:0]] = 1'b1;
    if (m_known) begin
      chk("gnt", 32'(gnt), 32'(eg));
      chk("valid", 32'(valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      if (m_phase == 2) begin
        chk("data", 32'(data), 32'(m_data));
        chk("id", 32'(id), 32'(m_id));
      end
`ifdef NAND_SCHED_STATS_EN
      chk("cnt", 32'(cnt), 32'(m_cnt));
`endif
    end
    last_k = k;
    if (!rs) begin
      m_known = 1;
      m_ptr   = 0;
      m_phase = 0;
      m_id    = 0;
      m_cnt   = 0;
      m_data  = '0;
    end else if (m_known && en) begin
      if (k >= 0) begin
        m_phase = 1;
        m_id    = k;
        m_ptr   = (k + 1) % N;
        m_data  = ~(a[k*W +: W] & b[k*W +: W]);
        m_cnt   = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && rdy) begin
        m_phase = 0;
      end
    end
  endtask

  int order_q[$];
  int cyc_q[$];

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    ready = 1'b0;
    req   = '0;
    opa   = '0;
    opb   = '0;
    step(0, 1, 1, '0, '0, '0);
    step(0, 1, 1, '0, '0, '0);

    // Single request on lane 2
    step(1, 1, 1, 4'b0100, 32'h00F0_0000, 32'h003C_0000);
    chk("t1_gnt", 32'(gnt), 32'h4);
    step(1, 1, 1, '0, '0, '0);
    chk("t1_eval_valid", 32'(valid), 32'h0);
    step(1, 1, 1, '0, '0, '0);
    chk("t1_data", 32'(data), 32'hCF);
    chk("t1_id", 32'(id), 32'h2);
    chk("t1_valid", 32'(valid), 32'h1);

    // Fairness from pointer 0
    step(0, 1, 1, '0, '0, '0);
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 1, 4'b1111, $urandom, $urandom);
      for (int j = 0; j < N; j++)
        if (gnt[j]) begin
          order_q.push_back(j);
          cyc_q.push_back(i);
        end
    end
    chk("rr_count", 32'(order_q.size()), 32'd5);
    for (int j = 0; j < order_q.size() && j < 5; j++) begin
      chk("rr_order", 32'(order_q[j]), 32'(j % N));
      if (j > 0) chk("rr_gap", 32'(cyc_q[j] - cyc_q[j-1]), 32'd3);
    end

    // Backpressure with all requests pending
    step(1, 1, 1, '0, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    step(1, 1, 0, 4'b0001, 32'h0000_00A5, 32'h0000_00FF);
    step(1, 1, 0, 4'b1111, '0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'b1111, $urandom, $urandom);
      chk("t3_hold", 32'(data), 32'h5A);
    end
    step(1, 1, 1, 4'b1111, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    chk("t3_released", 32'(valid), 32'h0);

    // Reset during evaluation
    step(1, 1, 1, 4'b1000, 32'hFF00_0000, 32'h1200_0000);
    step(0, 1, 1, '0, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    chk("t4_valid", 32'(valid), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_data", 32'(data), 32'h0);
    chk("t4_id", 32'(id), 32'h0);
    step(1, 1, 1, 4'b0010, $urandom, $urandom);
    chk("t4_gnt", 32'(gnt), 32'h2);

    // ena freeze in IDLE and in RESP
    step(1, 1, 1, '0, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    step(1, 0, 1, 4'b0001, $urandom, $urandom);
    chk("t5_idle_gnt", 32'(gnt), 32'h0);
    step(1, 1, 1, 4'b0001, $urandom, $urandom);
    step(1, 1, 1, '0, '0, '0);
    step(1, 0, 1, '0, '0, '0);
    step(1, 0, 1, '0, '0, '0);
    chk("t5_resp_hold", 32'(valid), 32'h1);
    step(1, 1, 1, '0, '0, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 1)),
           N'($urandom), $urandom, $urandom);
    end

`ifdef NAND_SCHED_STATS_EN
    step(0, 1, 1, '0, '0, '0);
    step(1, 1, 1, '0, '0, '0);
    chk("cnt_rst", 32'(cnt), 32'h0);
    for (int i = 0; i < 70; i++) step(1, 1, 1, 4'b1111, $urandom, $urandom);
    chk("cnt_sat", 32'(cnt), 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
